mul16_arbiter_seq: RTL and testbench

- Shares one iterative shift-add 16-bit multiplier between two requesters; a sibling to the combinational multiplier in the MiniAlu datapath.
- Targets multi-cycle MUL issue, where a second consumer (e.g. an address-generation unit) also needs products.
- Round-robin arbitration, registered grant/done handshake, low-WIDTH-bit product, same truncation as the MUL16BITS result.

---
 rtl/mul16_arbiter_seq_if.sv | 31 +++
 rtl/mul16_arbiter_seq.sv | 129 ++++++++++++
 tb/tb_mul16_arbiter_seq.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mul16_arbiter_seq_if.sv
// Purpose: request/operand/result bundle between two requesters and the shared multiplier.
// Latency: none (wires only).
// Backpressure: requests are held by the requester until the matching grant pulse.
interface mul16_arbiter_seq_if #(
    parameter int WIDTH = 16
);
    logic             iReq0;
    logic [WIDTH-1:0] iA0;
    logic [WIDTH-1:0] iB0;
    logic             iReq1;
    logic [WIDTH-1:0] iA1;
    logic [WIDTH-1:0] iB1;
    logic             oGrant0;
    logic             oGrant1;
    logic             oBusy;
    logic             oDone;
    logic             oOwner;
    logic [WIDTH-1:0] oResult;

    // Requester side: drives requests and operands, observes handshake and product.
    modport master (
        output iReq0, iA0, iB0, iReq1, iA1, iB1,
        input  oGrant0, oGrant1, oBusy, oDone, oOwner, oResult
    );

    // Multiplier side.
    modport slave (
        input  iReq0, iA0, iB0, iReq1, iA1, iB1,
        output oGrant0, oGrant1, oBusy, oDone, oOwner, oResult
    );
endinterface

// File: rtl/mul16_arbiter_seq.sv
// Purpose: round-robin shared iterative shift-add multiplier, low WIDTH bits of A*B.
// Latency: oDone in the cycle after accept edge + WIDTH; issue period WIDTH+2 cycles.
// Backpressure: requests are only sampled in IDLE; requesters hold iReq until their grant.
module mul16_arbiter_seq #(
    parameter int WIDTH = 16
) (
    input  logic                  Clock,
    input  logic                  Reset,
    mul16_arbiter_seq_if.slave    bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           stateNext;
    logic             accept;
    logic             winner;
    logic             lastIter;
    logic [WIDTH-1:0] accNext;

    logic [WIDTH-1:0] regA;
    logic [WIDTH-1:0] regB;
    logic [WIDTH-1:0] acc;
    logic [CW-1:0]    iterCnt;
    logic             lastServed;
    logic             grant0Q;
    logic             grant1Q;
    logic             busyQ;
    logic             doneQ;
    logic             ownerQ;
    logic [WIDTH-1:0] resultQ;

    // State register; reset aborts any operation in flight.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state, arbitration and the add step of the current iteration.
    always_comb begin
        stateNext = state;
        accept    = 1'b0;
        winner    = 1'b0;
        lastIter  = 1'b0;
        accNext   = regB[0] ? (acc + regA) : acc;
        case (state)
            IDLE: begin
                if (bus.iReq0 || bus.iReq1) begin
                    accept    = 1'b1;
                    // On a tie the requester not served last wins.
                    winner    = (bus.iReq0 && bus.iReq1) ? ~lastServed : bus.iReq1;
                    stateNext = CALC;
                end
            end
            CALC: begin
                // No early exit: always exactly WIDTH iterations.
                if (iterCnt == LAST_ITER) begin
                    lastIter  = 1'b1;
                    stateNext = DONE;
                end
            end
            DONE: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Operand capture, shift-add datapath and registered handshake outputs.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            regA       <= '0;
            regB       <= '0;
            acc        <= '0;
            iterCnt    <= '0;
            lastServed <= 1'b1;
            grant0Q    <= 1'b0;
            grant1Q    <= 1'b0;
            busyQ      <= 1'b0;
            doneQ      <= 1'b0;
            ownerQ     <= 1'b0;
            resultQ    <= '0;
        end else begin
            grant0Q <= 1'b0;
            grant1Q <= 1'b0;
            doneQ   <= 1'b0;
            if (accept) begin
                regA       <= winner ? bus.iA1 : bus.iA0;
                regB       <= winner ? bus.iB1 : bus.iB0;
                acc        <= '0;
                iterCnt    <= '0;
                ownerQ     <= winner;
                lastServed <= winner;
                grant0Q    <= ~winner;
                grant1Q    <= winner;
                busyQ      <= 1'b1;
            end else if (state == CALC) begin
                acc     <= accNext;
                regA    <= regA << 1;
                regB    <= regB >> 1;
                iterCnt <= iterCnt + CW'(1);
                if (lastIter) begin
                    resultQ <= accNext;
                    doneQ   <= 1'b1;
                end
            end else if (state == DONE) begin
                busyQ <= 1'b0;
            end
        end
    end

    assign bus.oGrant0 = grant0Q;
    assign bus.oGrant1 = grant1Q;
    assign bus.oBusy   = busyQ;
    assign bus.oDone   = doneQ;
    assign bus.oOwner  = ownerQ;
    assign bus.oResult = resultQ;
endmodule

// File: tb/tb_mul16_arbiter_seq.sv
// Purpose: directed test of the shared multiplier against a timing/arithmetic model.
// Latency: n/a.
// Backpressure: n/a.
module tb_mul16_arbiter_seq;
    localparam int W = 16;

    logic Clock = 1'b0;
    logic Reset;

    always #5 Clock = ~Clock;

    mul16_arbiter_seq_if #(.WIDTH(W)) bus();

    mul16_arbiter_seq #(.WIDTH(W)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    int nChecks = 0;
    int nPass   = 0;
    bit cmpOn   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act === exp) begin
            nPass++;
        end else begin
            $display("FAIL %s: got 0x%0h, need 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: an accepted op finishes WIDTH edges later, the arbiter is free again
    // WIDTH+1 edges after accept; the product is plain truncated multiplication.
    int          cyc = 0;
    int          k   = 0;
    bit          mIdle = 1'b1;
    logic        mLast = 1'b1;
    logic        mGrant0 = 1'b0;
    logic        mGrant1 = 1'b0;
    logic        mBusy = 1'b0;
    logic        mDone = 1'b0;
    logic        mOwner = 1'b0;
    logic [15:0] mResult = '0;
    logic [15:0] mProd = '0;

    initial begin
        logic        w;
        logic [31:0] p;
        forever begin
            @(posedge Clock);
            cyc++;
            if (!Reset) begin
                mIdle = 1'b1; mLast = 1'b1; mGrant0 = 1'b0; mGrant1 = 1'b0;
                mBusy = 1'b0; mDone = 1'b0; mOwner = 1'b0; mResult = '0;
            end else begin
                mGrant0 = 1'b0;
                mGrant1 = 1'b0;
                mDone   = 1'b0;
                if (mIdle) begin
                    if (bus.iReq0 || bus.iReq1) begin
                        w = (bus.iReq0 && bus.iReq1) ? !mLast : bus.iReq1;
                        p = w ? (32'(bus.iA1) * 32'(bus.iB1)) : (32'(bus.iA0) * 32'(bus.iB0));
                        mProd   = p[15:0];
                        mOwner  = w;
                        mLast   = w;
                        mGrant0 = !w;
                        mGrant1 = w;
                        mBusy   = 1'b1;
                        mIdle   = 1'b0;
                        k       = 0;
                    end
                end else begin
                    k++;
                    if (k == W) begin
                        mDone   = 1'b1;
                        mResult = mProd;
                    end else if (k == W + 1) begin
                        mBusy = 1'b0;
                        mIdle = 1'b1;
                    end
                end
            end
        end
    end

    // Every cycle, compare all outputs against the model away from the active edge.
    always @(negedge Clock) begin
        if (cmpOn) begin
            check("cyc oGrant0", bus.oGrant0, mGrant0);
            check("cyc oGrant1", bus.oGrant1, mGrant1);
            check("cyc oBusy",   bus.oBusy,   mBusy);
            check("cyc oDone",   bus.oDone,   mDone);
            check("cyc oOwner",  bus.oOwner,  mOwner);
            check("cyc oResult", bus.oResult, mResult);
        end
    end

    task automatic waitGrant(input bit who, output int g);
        bit seen;
        seen = 1'b0;
        g = -1;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge Clock);
            if ((!who && bus.oGrant0) || (who && bus.oGrant1)) begin
                seen = 1'b1;
                g = cyc;
            end
        end
        if (!seen) check("grant timeout", 32'd0, 32'd1);
    endtask

    task automatic waitDone(output int d, output logic [15:0] res, output logic own);
        bit seen;
        seen = 1'b0;
        d = -1;
        res = 'x;
        own = 'x;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge Clock);
            if (bus.oDone) begin
                seen = 1'b1;
                d = cyc;
                res = bus.oResult;
                own = bus.oOwner;
            end
        end
        if (!seen) check("done timeout", 32'd0, 32'd1);
    endtask

    task automatic issue(input bit who, input logic [15:0] a, input logic [15:0] b,
                         output int g, output int d, output logic [15:0] res, output logic own);
        if (who) begin
            bus.iA1 = a; bus.iB1 = b; bus.iReq1 = 1'b1;
        end else begin
            bus.iA0 = a; bus.iB0 = b; bus.iReq0 = 1'b1;
        end
        waitGrant(who, g);
        if (who) bus.iReq1 = 1'b0;
        else     bus.iReq0 = 1'b0;
        waitDone(d, res, own);
    endtask

    initial begin
        int          g, d, relCyc, g0, g1, nDone;
        logic [15:0] res;
        logic        own;
        int          gWho[$];
        int          gAt[$];
        logic [15:0] rs[$];

        // Reset held three cycles with both requesting.
        Reset = 1'b0;
        bus.iReq0 = 1'b1; bus.iA0 = 16'd2; bus.iB0 = 16'd3;
        bus.iReq1 = 1'b1; bus.iA1 = 16'h1111; bus.iB1 = 16'd2;
        @(negedge Clock);
        cmpOn = 1'b1;
        repeat (2) @(negedge Clock);
        check("rst oGrant0", bus.oGrant0, 0);
        check("rst oGrant1", bus.oGrant1, 0);
        check("rst oBusy",   bus.oBusy,   0);
        check("rst oDone",   bus.oDone,   0);
        check("rst oResult", bus.oResult, 16'h0000);
        relCyc = cyc;
        Reset = 1'b1;
        waitGrant(1'b0, g);
        check("release grant0 timing", g, relCyc + 1);
        bus.iReq0 = 1'b0;
        bus.iReq1 = 1'b0;
        waitDone(d, res, own);
        check("release op 2*3", res, 16'h0006);

        // Single request.
        issue(1'b0, 16'd3, 16'd5, g, d, res, own);
        check("single result", res, 16'h000F);
        check("single owner", own, 0);
        check("single latency", d - g, 16);
        repeat (3) @(negedge Clock);
        check("single hold", bus.oResult, 16'h000F);

        // Truncation and zero operand.
        issue(1'b1, 16'hFFFF, 16'hFFFF, g, d, res, own);
        check("trunc ffff^2", res, 16'h0001);
        check("trunc owner", own, 1);
        issue(1'b1, 16'h0100, 16'h0100, g, d, res, own);
        check("trunc 0100^2", res, 16'h0000);
        issue(1'b1, 16'h0000, 16'h1234, g, d, res, own);
        check("zero result", res, 16'h0000);
        check("zero latency", d - g, 16);

        // Round-robin with both requesters continuously high.
        bus.iA0 = 16'd7;    bus.iB0 = 16'd9;    bus.iReq0 = 1'b1;
        bus.iA1 = 16'h0010; bus.iB1 = 16'h0010; bus.iReq1 = 1'b1;
        for (int i = 0; i < 200 && rs.size() < 4; i++) begin
            @(negedge Clock);
            if (bus.oGrant0) begin gWho.push_back(0); gAt.push_back(cyc); end
            if (bus.oGrant1) begin gWho.push_back(1); gAt.push_back(cyc); end
            if (gWho.size() >= 4) begin bus.iReq0 = 1'b0; bus.iReq1 = 1'b0; end
            if (bus.oDone) rs.push_back(bus.oResult);
        end
        bus.iReq0 = 1'b0;
        bus.iReq1 = 1'b0;
        check("rr grant count", gWho.size(), 4);
        check("rr result count", rs.size(), 4);
        for (int i = 0; i < gWho.size(); i++) check("rr grant order", gWho[i], i % 2);
        for (int i = 1; i < gAt.size(); i++) check("rr accept spacing", gAt[i] - gAt[i-1], 18);
        for (int i = 0; i < rs.size(); i++)
            check("rr result", rs[i], (i % 2 == 0) ? 16'h003F : 16'h0100);
        repeat (3) @(negedge Clock);

        // Request raised while busy is held off until IDLE.
        bus.iA0 = 16'd1; bus.iB0 = 16'd1; bus.iReq0 = 1'b1;
        waitGrant(1'b0, g0);
        bus.iReq0 = 1'b0;
        repeat (4) @(negedge Clock);
        bus.iA1 = 16'd2; bus.iB1 = 16'd3; bus.iReq1 = 1'b1;
        waitGrant(1'b1, g1);
        bus.iReq1 = 1'b0;
        check("busy-ignore grant1 gap", g1 - g0, 18);
        waitDone(d, res, own);
        check("busy-ignore result", res, 16'h0006);
        check("busy-ignore owner", own, 1);

        // Reset at iteration 8 aborts the operation.
        bus.iA0 = 16'h00FF; bus.iB0 = 16'h0003; bus.iReq0 = 1'b1;
        waitGrant(1'b0, g);
        bus.iReq0 = 1'b0;
        repeat (7) @(negedge Clock);
        Reset = 1'b0;
        @(negedge Clock);
        Reset = 1'b1;
        nDone = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge Clock);
            if (bus.oDone) nDone++;
        end
        check("abort no done", nDone, 0);
        check("abort result", bus.oResult, 16'h0000);
        check("abort busy", bus.oBusy, 0);
        issue(1'b1, 16'd2, 16'd2, g, d, res, own);
        check("post-abort result", res, 16'h0004);
        check("post-abort owner", own, 1);

        repeat (3) @(negedge Clock);
        cmpOn = 1'b0;
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end
endmodule
